// File: rtl/bird_collision_ctrl_pkg.sv
// Shared game definitions: coordinate width, floor derivation, FSM encodings and
// the geometry and flag payloads passed between pipeline stages.
package bird_collision_ctrl_pkg;

  localparam int unsigned CW          = 12;
  localparam int unsigned DISP_H      = 480;
  localparam int unsigned GROUND_H    = 30;
  localparam int unsigned FLOOR_Y_DEF = DISP_H - GROUND_H;
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_READY   = 2'b00,
    ST_PLAYING = 2'b01,
    ST_DEAD    = 2'b10
  } game_state_e;

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
  } box_t;

  typedef struct packed {
    box_t   bird;
    coord_t pipe_x1;
    coord_t pipe_x2;
    coord_t gap_y1;
    coord_t gap_y2;
  } frame_geom_t;

  typedef struct packed {
    logic hx;
    logic hy;
    logic floor_hit;
    logic past;
  } hit_flags_t;

endpackage

// File: rtl/bird_collision_ctrl_if.sv
// Controller-facing bundle: per-frame geometry and button in, game control and status out.
interface bird_collision_ctrl_if #(
  parameter int unsigned SCORE_W = 8
);
  import bird_collision_ctrl_pkg::*;

  logic                 i_frame_stb;
  logic                 i_flap_req;
  coord_t               i_bird_x1;
  coord_t               i_bird_x2;
  coord_t               i_bird_y1;
  coord_t               i_bird_y2;
  coord_t               i_pipe_x1;
  coord_t               i_pipe_x2;
  coord_t               i_gap_y1;
  coord_t               i_gap_y2;
  logic                 o_flap;
  logic                 o_animate;
  logic                 o_game_rst;
  logic                 o_hit;
  logic [STATE_W-1:0]   o_state;
  logic [SCORE_W-1:0]   o_score;

  modport slave (
    input  i_frame_stb, i_flap_req,
    input  i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2,
    input  i_pipe_x1, i_pipe_x2, i_gap_y1, i_gap_y2,
    output o_flap, o_animate, o_game_rst, o_hit, o_state, o_score
  );

  modport master (
    output i_frame_stb, i_flap_req,
    output i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2,
    output i_pipe_x1, i_pipe_x2, i_gap_y1, i_gap_y2,
    input  o_flap, o_animate, o_game_rst, o_hit, o_state, o_score
  );

endinterface

// File: rtl/bird_collision_ctrl_overlap.sv
// Combinational box test: horizontal overlap with the pipe, vertical escape from
// the gap, and whether the bird has fully cleared the pipe's right edge.
module bird_box_overlap
  import bird_collision_ctrl_pkg::*;
(
  input  box_t   bird_i,
  input  coord_t pipe_x1_i,
  input  coord_t pipe_x2_i,
  input  coord_t gap_y1_i,
  input  coord_t gap_y2_i,
  output logic   hx_o,
  output logic   hy_o,
  output logic   past_o
);

  assign hx_o   = (bird_i.x2 > pipe_x1_i) && (bird_i.x1 < pipe_x2_i);
  assign hy_o   = (bird_i.y1 < gap_y1_i) || (bird_i.y2 > gap_y2_i);
  assign past_o = (bird_i.x1 >= pipe_x2_i);

endmodule

// File: rtl/bird_collision_ctrl.sv
// Per-frame collision/score pipeline feeding the READY/PLAYING/DEAD game FSM.
module bird_collision_ctrl
  import bird_collision_ctrl_pkg::*;
#(
  parameter int unsigned FLOOR_Y     = FLOOR_Y_DEF,
  parameter int unsigned DEAD_FRAMES = 60,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bird_collision_ctrl_if.slave bus
);

  localparam int unsigned DCW = (DEAD_FRAMES < 1) ? 1 : $clog2(DEAD_FRAMES + 1);
  localparam logic [DCW-1:0] DEAD_INIT = DCW'(DEAD_FRAMES);
  localparam coord_t         FLOOR_C   = CW'(FLOOR_Y);

  frame_geom_t        geom_in;
  frame_geom_t        geom_q;
  logic               v1_q;
  hit_flags_t         flags_d;
  hit_flags_t         flags_q;
  logic               v2_q;

  game_state_e        state_q, state_d;
  logic               flap_q, flap_d;
  logic               hit_q, hit_d;
  logic               game_rst_q, game_rst_d;
  logic               animate_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               prev_past_q, prev_past_d;
  logic [DCW-1:0]     dead_cnt_q, dead_cnt_d;
  logic               hit_now;
  logic               pass_now;

  always_comb begin
    geom_in         = '0;
    geom_in.bird.x1 = bus.i_bird_x1;
    geom_in.bird.x2 = bus.i_bird_x2;
    geom_in.bird.y1 = bus.i_bird_y1;
    geom_in.bird.y2 = bus.i_bird_y2;
    geom_in.pipe_x1 = bus.i_pipe_x1;
    geom_in.pipe_x2 = bus.i_pipe_x2;
    geom_in.gap_y1  = bus.i_gap_y1;
    geom_in.gap_y2  = bus.i_gap_y2;
  end

  // S0: capture geometry on the frame strobe; a new strobe simply overwrites.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q   <= 1'b0;
      geom_q <= '0;
    end else begin
      v1_q <= bus.i_frame_stb;
      if (bus.i_frame_stb) geom_q <= geom_in;
    end
  end

  bird_box_overlap u_overlap (
    .bird_i    (geom_q.bird),
    .pipe_x1_i (geom_q.pipe_x1),
    .pipe_x2_i (geom_q.pipe_x2),
    .gap_y1_i  (geom_q.gap_y1),
    .gap_y2_i  (geom_q.gap_y2),
    .hx_o      (flags_d.hx),
    .hy_o      (flags_d.hy),
    .past_o    (flags_d.past)
  );

  assign flags_d.floor_hit = (geom_q.bird.y2 >= FLOOR_C);

  // S1: register the collision flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) flags_q <= flags_d;
    end
  end

  assign hit_now  = v2_q && ((flags_q.hx && flags_q.hy) || flags_q.floor_hit);
  assign pass_now = v2_q && flags_q.past && !prev_past_q;

  // S2: game FSM; a hit outranks both a same-cycle flap and a same-cycle pass.
  always_comb begin
    state_d     = state_q;
    flap_d      = 1'b0;
    hit_d       = 1'b0;
    game_rst_d  = 1'b0;
    score_d     = score_q;
    dead_cnt_d  = dead_cnt_q;
    prev_past_d = v2_q ? flags_q.past : prev_past_q;
    unique case (state_q)
      ST_READY: begin
        if (bus.i_flap_req) begin
          state_d = ST_PLAYING;
          flap_d  = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (hit_now) begin
          state_d    = ST_DEAD;
          hit_d      = 1'b1;
          dead_cnt_d = DEAD_INIT;
        end else begin
          if (pass_now && (score_q != '1)) score_d = score_q + SCORE_W'(1);
          flap_d = bus.i_flap_req;
        end
      end
      ST_DEAD: begin
        if (bus.i_frame_stb && (dead_cnt_q != '0)) dead_cnt_d = dead_cnt_q - DCW'(1);
        if (bus.i_flap_req && (dead_cnt_q == '0)) begin
          state_d     = ST_READY;
          game_rst_d  = 1'b1;
          score_d     = '0;
          prev_past_d = 1'b0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_READY;
      flap_q      <= 1'b0;
      hit_q       <= 1'b0;
      game_rst_q  <= 1'b0;
      animate_q   <= 1'b0;
      score_q     <= '0;
      prev_past_q <= 1'b0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flap_q      <= flap_d;
      hit_q       <= hit_d;
      game_rst_q  <= game_rst_d;
      animate_q   <= (state_d == ST_PLAYING);
      score_q     <= score_d;
      prev_past_q <= prev_past_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  assign bus.o_flap     = flap_q;
  assign bus.o_animate  = animate_q;
  assign bus.o_game_rst = game_rst_q;
  assign bus.o_hit      = hit_q;
  assign bus.o_state    = state_q;
  assign bus.o_score    = score_q;

endmodule

// File: tb/tb_bird_collision_ctrl.sv
// Directed game scenarios plus random frames/flaps/resets, scored against a
// frame-level model of the game rules.
module tb_bird_collision_ctrl;

  localparam int unsigned DF    = 3;
  localparam int unsigned SW    = 8;
  localparam int unsigned FLOOR = 450;
  localparam int unsigned SMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bird_collision_ctrl_if #(.SCORE_W(SW)) bus ();

  bird_collision_ctrl #(
    .FLOOR_Y     (FLOOR),
    .DEAD_FRAMES (DF),
    .SCORE_W     (SW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Model: 0 READY, 1 PLAYING, 2 DEAD
  int unsigned m_state, m_score, m_cnt;
  bit          m_pp;
  int unsigned g [8];  // bird x1,x2,y1,y2, pipe x1,x2, gap y1,y2

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_geom(input int unsigned bx1, bx2, by1, by2, px1, px2, gy1, gy2);
    g[0] = bx1; g[1] = bx2; g[2] = by1; g[3] = by2;
    g[4] = px1; g[5] = px2; g[6] = gy1; g[7] = gy2;
    bus.i_bird_x1 = 12'(bx1); bus.i_bird_x2 = 12'(bx2);
    bus.i_bird_y1 = 12'(by1); bus.i_bird_y2 = 12'(by2);
    bus.i_pipe_x1 = 12'(px1); bus.i_pipe_x2 = 12'(px2);
    bus.i_gap_y1  = 12'(gy1); bus.i_gap_y2  = 12'(gy2);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_state"},   bus.o_state,   m_state);
    chk({tag, "_score"},   bus.o_score,   m_score);
    chk({tag, "_animate"}, bus.o_animate, (m_state == 1) ? 1 : 0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_state = 0; m_score = 0; m_cnt = 0; m_pp = 1'b0;
    chk("rst_hit", bus.o_hit, 0);
    chk("rst_flap", bus.o_flap, 0);
    chk("rst_game_rst", bus.o_game_rst, 0);
    check_status("rst");
    tick();
    chk("rst_game_rst_after", bus.o_game_rst, 0);
  endtask

  // One frame through the pipeline; optional flap lands on the cycle the flags are consumed.
  task automatic do_frame(input bit flap_v2);
    bit hx, hy, fl, hit, past, e_hit, e_flap, e_rst;
    hx   = (g[1] > g[4]) && (g[0] < g[5]);
    hy   = (g[2] < g[6]) || (g[3] > g[7]);
    fl   = (g[3] >= FLOOR);
    hit  = (hx && hy) || fl;
    past = (g[0] >= g[5]);
    e_hit = 1'b0; e_flap = 1'b0; e_rst = 1'b0;
    tick();
    bus.i_frame_stb = 1'b1;
    tick();
    bus.i_frame_stb = 1'b0;
    if (m_state == 2 && m_cnt != 0) m_cnt--;
    tick();
    chk("hit_early", bus.o_hit, 0);
    bus.i_flap_req = flap_v2;
    tick();
    bus.i_flap_req = 1'b0;
    case (m_state)
      0: begin
        m_pp = past;
        if (flap_v2) begin m_state = 1; e_flap = 1'b1; end
      end
      1: begin
        if (hit) begin
          m_state = 2; m_cnt = DF; e_hit = 1'b1;
        end else begin
          if (past && !m_pp && m_score < SMAX) m_score++;
          e_flap = flap_v2;
        end
        m_pp = past;
      end
      default: begin
        m_pp = past;
        if (flap_v2 && m_cnt == 0) begin
          m_state = 0; m_score = 0; m_pp = 1'b0; e_rst = 1'b1;
        end
      end
    endcase
    chk("frame_hit", bus.o_hit, e_hit);
    chk("frame_flap", bus.o_flap, e_flap);
    chk("frame_game_rst", bus.o_game_rst, e_rst);
    check_status("frame");
    tick();
    chk("hit_pulse_width", bus.o_hit, 0);
    chk("flap_pulse_width", bus.o_flap, 0);
  endtask

  task automatic do_flap();
    bit e_flap, e_rst;
    e_flap = 1'b0; e_rst = 1'b0;
    tick();
    bus.i_flap_req = 1'b1;
    tick();
    bus.i_flap_req = 1'b0;
    case (m_state)
      0: begin m_state = 1; e_flap = 1'b1; end
      1: e_flap = 1'b1;
      default: if (m_cnt == 0) begin
        m_state = 0; m_score = 0; m_pp = 1'b0; e_rst = 1'b1;
      end
    endcase
    chk("flap_out", bus.o_flap, e_flap);
    chk("flap_game_rst", bus.o_game_rst, e_rst);
    chk("flap_hit", bus.o_hit, 0);
    check_status("flap");
    tick();
    chk("flap_out_width", bus.o_flap, 0);
    chk("game_rst_width", bus.o_game_rst, 0);
  endtask

  task automatic restart_and_play();
    for (int i = 0; i < int'(DF); i++) do_frame(1'b0);
    do_flap();
    do_flap();
  endtask

  initial begin
    bus.i_frame_stb = 1'b0;
    bus.i_flap_req  = 1'b0;
    set_geom(280, 360, 200, 280, 500, 560, 150, 300);
    m_state = 0; m_score = 0; m_cnt = 0; m_pp = 1'b0;
    repeat (3) tick();

    // Idle frames in READY
    do_reset();
    for (int i = 0; i < 3; i++) do_frame(1'b0);

    // Start, overlap inside gap, then gap moves down onto the bird
    do_flap();
    set_geom(280, 360, 200, 280, 340, 400, 150, 300);
    do_frame(1'b0);
    set_geom(280, 360, 200, 280, 340, 400, 220, 300);
    do_frame(1'b0);

    // Dead hold-off: early flaps ignored, flap after the last dead frame restarts
    do_frame(1'b0); do_flap();
    do_frame(1'b0); do_flap();
    do_frame(1'b0); do_flap();
    do_flap();

    // Floor hit without pipe overlap
    set_geom(280, 360, 420, 450, 500, 560, 150, 300);
    do_frame(1'b0);
    restart_and_play();

    // Pass edge, then held past, then pipe wrap
    set_geom(400, 480, 200, 280, 340, 401, 150, 300); do_frame(1'b0);
    set_geom(400, 480, 200, 280, 340, 400, 150, 300); do_frame(1'b0);
    set_geom(400, 480, 200, 280, 330, 390, 150, 300); do_frame(1'b0);
    set_geom(400, 480, 200, 280, 500, 560, 150, 300); do_frame(1'b0);

    // Hit and flap together
    set_geom(280, 360, 200, 280, 340, 400, 220, 300);
    do_frame(1'b1);
    restart_and_play();

    // Reset in the middle of a game
    do_reset();
    do_flap();

    // Score saturation
    for (int i = 0; i < 258; i++) begin
      set_geom(280, 360, 200, 280, 500, 560, 150, 300); do_frame(1'b0);
      set_geom(280, 360, 200, 280, 100, 200, 150, 300); do_frame(1'b0);
    end
    chk("score_saturated", bus.o_score, SMAX);

    // Random play
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int unsigned r, bx1, bx2, by1, by2, px1, px2, gy1, gy2;
      r   = $urandom_range(0, 99);
      bx1 = $urandom_range(200, 300);
      bx2 = bx1 + $urandom_range(34, 80);
      gy1 = $urandom_range(50, 300);
      gy2 = gy1 + $urandom_range(100, 160);
      if ($urandom_range(0, 1) == 0) begin
        by1 = gy1 + $urandom_range(0, 20);
        by2 = by1 + $urandom_range(24, 40);
      end else begin
        by1 = $urandom_range(0, 430);
        by2 = by1 + $urandom_range(24, 50);
      end
      px1 = $urandom_range(0, 600);
      px2 = px1 + $urandom_range(52, 80);
      set_geom(bx1, bx2, by1, by2, px1, px2, gy1, gy2);
      if (r < 65)      do_frame($urandom_range(0, 4) == 0);
      else if (r < 95) do_flap();
      else             do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
